// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU->ROCSTAR 4-bit cable link.
// The transmitter and the receive-side checker both import this package, so
// the idle code table and its phase mapping exist in exactly one place.
//   IDLE0..IDLE3 : idle sequence codes, transmitted in order and repeating
//   link_state_e : receive-side lock state encoding
//   decode_idle  : maps a cable word to {valid, phase}
package mcu_link_pkg;

    localparam logic [3:0] IDLE0 = 4'b0111;
    localparam logic [3:0] IDLE1 = 4'b1011;
    localparam logic [3:0] IDLE2 = 4'b1101;
    localparam logic [3:0] IDLE3 = 4'b1110;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StLocked = 2'd1,
        StSlip   = 2'd2
    } link_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] phase;
    } idle_dec_t;

    function automatic idle_dec_t decode_idle(input logic [3:0] code);
        idle_dec_t dec;
        dec.valid = 1'b1;
        dec.phase = 2'd0;
        case (code)
            IDLE0:   dec.phase = 2'd0;
            IDLE1:   dec.phase = 2'd1;
            IDLE2:   dec.phase = 2'd2;
            IDLE3:   dec.phase = 2'd3;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one unless already all-ones
//   clr        : force to zero; takes priority over inc
//   cnt        : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/idle_link_rx.sv
// Receive-side idle-pattern checker for one 4-bit MCU->ROCSTAR cable.
// Locks onto the rotating idle sequence, tracks its phase and counts
// corrupted or out-of-sequence words while locked.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : cable word from the transmitter
//   clear_cnt   : synchronous clear of err_cnt and relock_cnt
//   locked      : high in LOCKED and SLIP
//   phase       : phase of the registered word while locked, else 0
//   err_cnt     : saturating count of bad words seen while locked
//   relock_cnt  : saturating count of HUNT->LOCKED transitions
//   lock_lost   : one-cycle pulse when lock is dropped
module idle_link_rx
    import mcu_link_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       relock_cnt,
    output logic             lock_lost
);

    localparam logic [7:0] LockCnt   = 8'(LOCK_COUNT);
    localparam logic [7:0] UnlockCnt = 8'(UNLOCK_ERRS);

    logic [3:0]  din_q;
    link_state_e state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  bad_q, bad_d;
    logic [1:0]  exp_q, exp_d;
    logic        lock_lost_q, lock_lost_d;
    logic        err_inc, relock_inc;

    idle_dec_t   dec;
    logic        good;
    logic [7:0]  run_inc, bad_inc;

    assign dec     = decode_idle(din_q);
    assign good    = dec.valid && (dec.phase == exp_q);
    assign run_inc = run_q + 8'd1;
    assign bad_inc = bad_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        bad_d       = bad_q;
        exp_d       = exp_q;
        lock_lost_d = 1'b0;
        err_inc     = 1'b0;
        relock_inc  = 1'b0;
        case (state_q)
            StHunt: begin
                if (!dec.valid) begin
                    run_d = 8'd0;
                end else begin
                    exp_d = dec.phase + 2'd1;
                    // A valid word with no run in progress, or one that breaks
                    // the sequence, starts a fresh run of length one.
                    if ((run_q == 8'd0) || !good) begin
                        run_d = 8'd1;
                    end else if (run_inc == LockCnt) begin
                        state_d    = StLocked;
                        relock_inc = 1'b1;
                        run_d      = 8'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
            StLocked: begin
                // exp free-runs once locked so a corrupted word does not
                // shift the expected phase of the words that follow it.
                exp_d = exp_q + 2'd1;
                if (!good) begin
                    err_inc = 1'b1;
                    if (UnlockCnt == 8'd1) begin
                        state_d     = StHunt;
                        run_d       = 8'd0;
                        bad_d       = 8'd0;
                        lock_lost_d = 1'b1;
                    end else begin
                        state_d = StSlip;
                        bad_d   = 8'd1;
                    end
                end
            end
            StSlip: begin
                exp_d = exp_q + 2'd1;
                if (good) begin
                    state_d = StLocked;
                    bad_d   = 8'd0;
                end else begin
                    err_inc = 1'b1;
                    if (bad_inc == UnlockCnt) begin
                        state_d     = StHunt;
                        run_d       = 8'd0;
                        bad_d       = 8'd0;
                        lock_lost_d = 1'b1;
                    end else begin
                        bad_d = bad_inc;
                    end
                end
            end
            default: begin
                state_d = StHunt;
                run_d   = 8'd0;
                bad_d   = 8'd0;
                exp_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q       <= 4'd0;
            state_q     <= StHunt;
            run_q       <= 8'd0;
            bad_q       <= 8'd0;
            exp_q       <= 2'd0;
            lock_lost_q <= 1'b0;
        end else begin
            din_q       <= din;
            state_q     <= state_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            exp_q       <= exp_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clear_cnt),
        .cnt   (err_cnt)
    );

    sat_counter #(
        .W (8)
    ) u_relock_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (relock_inc),
        .clr   (clear_cnt),
        .cnt   (relock_cnt)
    );

    assign locked    = (state_q == StLocked) || (state_q == StSlip);
    // A corrupted word has no phase of its own; report the slot it occupied.
    assign phase     = !locked ? 2'd0 : (dec.valid ? dec.phase : exp_q);
    assign lock_lost = lock_lost_q;

endmodule
